// File: rtl/jtag_pkg.sv
// Shared JTAG TAP definitions.
//   tap_state_t    : 16 TAP states, standard IEEE 1149.1 4-bit encodings
//   is_ir_branch() : state is one of SEL_IR..UPDATE_IR
//   is_shift()     : state is SHIFT_IR or SHIFT_DR
package jtag_pkg;

    typedef enum logic [3:0] {
        EXIT2_DR  = 4'h0,
        EXIT1_DR  = 4'h1,
        SHIFT_DR  = 4'h2,
        PAUSE_DR  = 4'h3,
        SEL_IR    = 4'h4,
        UPDATE_DR = 4'h5,
        CAP_DR    = 4'h6,
        SEL_DR    = 4'h7,
        EXIT2_IR  = 4'h8,
        EXIT1_IR  = 4'h9,
        SHIFT_IR  = 4'hA,
        PAUSE_IR  = 4'hB,
        RTI       = 4'hC,
        UPDATE_IR = 4'hD,
        CAP_IR    = 4'hE,
        TLR       = 4'hF
    } tap_state_t;

    function automatic logic is_ir_branch(tap_state_t s);
        return s inside {SEL_IR, CAP_IR, SHIFT_IR, EXIT1_IR, PAUSE_IR, EXIT2_IR, UPDATE_IR};
    endfunction

    function automatic logic is_shift(tap_state_t s);
        return s inside {SHIFT_IR, SHIFT_DR};
    endfunction

endpackage

// File: rtl/tap_controller_if.sv
// TAP controller control bundle.
//   tms                  : mode select from the JTAG pin
//   state                : current TAP state
//   tl_reset             : active-low test-logic reset
//   captureX/shiftX      : posedge-domain capture/shift controls (X = IR/DR)
//   clk_X_en             : shift-clock enable for the IR/DR chain
//   updateX              : negedge-domain update strobes
//   ir_select            : 1 = IR path drives tdo
//   tdo_en               : tdo output-buffer enable
// master: drives tms, observes controls. slave: the TAP controller itself.
interface tap_controller_if;
    import jtag_pkg::*;

    logic       tms;
    tap_state_t state;
    logic       tl_reset;
    logic       captureIR;
    logic       shiftIR;
    logic       updateIR;
    logic       clk_ir_en;
    logic       captureDR;
    logic       shiftDR;
    logic       updateDR;
    logic       clk_dr_en;
    logic       ir_select;
    logic       tdo_en;

    modport master (
        output tms,
        input  state, tl_reset, captureIR, shiftIR, updateIR, clk_ir_en,
        input  captureDR, shiftDR, updateDR, clk_dr_en, ir_select, tdo_en
    );

    modport slave (
        input  tms,
        output state, tl_reset, captureIR, shiftIR, updateIR, clk_ir_en,
        output captureDR, shiftDR, updateDR, clk_dr_en, ir_select, tdo_en
    );

endinterface

// File: rtl/tap_controller.sv
// IEEE 1149.1 TAP controller.
//   tck  : test clock, state advances on posedge
//   trst : asynchronous active-high reset, forces TLR
//   bus  : tap_controller_if.slave (tms in, state and IR/DR controls out)
// Capture/shift/clk_en controls are posedge flops loaded from the next-state
// decode, so they track the current state glitch-free. tl_reset, update
// strobes, tdo_en and ir_select are negedge flops so they change mid-state.
module tap_controller
    import jtag_pkg::*;
(
    input  logic             tck,
    input  logic             trst,
    tap_controller_if.slave  bus
);

    tap_state_t state_q;
    tap_state_t next_state;

    // Posedge-domain controls
    logic capture_ir_d, shift_ir_d, clk_ir_en_d;
    logic capture_dr_d, shift_dr_d, clk_dr_en_d;
    logic capture_ir_q, shift_ir_q, clk_ir_en_q;
    logic capture_dr_q, shift_dr_q, clk_dr_en_q;

    // Negedge-domain controls
    logic tl_reset_d, update_ir_d, update_dr_d, tdo_en_d, ir_select_d;
    logic tl_reset_q, update_ir_q, update_dr_q, tdo_en_q, ir_select_q;

    // State register
    always_ff @(posedge tck or posedge trst) begin
        if (trst) begin
            state_q <= TLR;
        end else begin
            state_q <= next_state;
        end
    end

    // Next-state logic
    always_comb begin
        next_state = state_q;
        unique case (state_q)
            TLR:       next_state = bus.tms ? TLR       : RTI;
            RTI:       next_state = bus.tms ? SEL_DR    : RTI;
            SEL_DR:    next_state = bus.tms ? SEL_IR    : CAP_DR;
            CAP_DR:    next_state = bus.tms ? EXIT1_DR  : SHIFT_DR;
            SHIFT_DR:  next_state = bus.tms ? EXIT1_DR  : SHIFT_DR;
            EXIT1_DR:  next_state = bus.tms ? UPDATE_DR : PAUSE_DR;
            PAUSE_DR:  next_state = bus.tms ? EXIT2_DR  : PAUSE_DR;
            EXIT2_DR:  next_state = bus.tms ? UPDATE_DR : SHIFT_DR;
            UPDATE_DR: next_state = bus.tms ? SEL_DR    : RTI;
            SEL_IR:    next_state = bus.tms ? TLR       : CAP_IR;
            CAP_IR:    next_state = bus.tms ? EXIT1_IR  : SHIFT_IR;
            SHIFT_IR:  next_state = bus.tms ? EXIT1_IR  : SHIFT_IR;
            EXIT1_IR:  next_state = bus.tms ? UPDATE_IR : PAUSE_IR;
            PAUSE_IR:  next_state = bus.tms ? EXIT2_IR  : PAUSE_IR;
            EXIT2_IR:  next_state = bus.tms ? UPDATE_IR : SHIFT_IR;
            UPDATE_IR: next_state = bus.tms ? SEL_DR    : RTI;
        endcase
    end

    // Output decode: posedge flops look at next_state, negedge flops at the
    // state that is current during the low half of tck.
    always_comb begin
        capture_ir_d = (next_state == CAP_IR);
        shift_ir_d   = (next_state == SHIFT_IR);
        clk_ir_en_d  = (next_state == CAP_IR) || (next_state == SHIFT_IR);
        capture_dr_d = (next_state == CAP_DR);
        shift_dr_d   = (next_state == SHIFT_DR);
        clk_dr_en_d  = (next_state == CAP_DR) || (next_state == SHIFT_DR);

        tl_reset_d   = (state_q != TLR);
        update_ir_d  = (state_q == UPDATE_IR);
        update_dr_d  = (state_q == UPDATE_DR);
        tdo_en_d     = is_shift(state_q);
        ir_select_d  = is_ir_branch(state_q) || (state_q == TLR);
    end

    always_ff @(posedge tck or posedge trst) begin
        if (trst) begin
            capture_ir_q <= 1'b0;
            shift_ir_q   <= 1'b0;
            clk_ir_en_q  <= 1'b0;
            capture_dr_q <= 1'b0;
            shift_dr_q   <= 1'b0;
            clk_dr_en_q  <= 1'b0;
        end else begin
            capture_ir_q <= capture_ir_d;
            shift_ir_q   <= shift_ir_d;
            clk_ir_en_q  <= clk_ir_en_d;
            capture_dr_q <= capture_dr_d;
            shift_dr_q   <= shift_dr_d;
            clk_dr_en_q  <= clk_dr_en_d;
        end
    end

    // A reset here also kills an update pulse already in flight.
    always_ff @(negedge tck or posedge trst) begin
        if (trst) begin
            tl_reset_q  <= 1'b0;
            update_ir_q <= 1'b0;
            update_dr_q <= 1'b0;
            tdo_en_q    <= 1'b0;
            ir_select_q <= 1'b1;
        end else begin
            tl_reset_q  <= tl_reset_d;
            update_ir_q <= update_ir_d;
            update_dr_q <= update_dr_d;
            tdo_en_q    <= tdo_en_d;
            ir_select_q <= ir_select_d;
        end
    end

    assign bus.state     = state_q;
    assign bus.captureIR = capture_ir_q;
    assign bus.shiftIR   = shift_ir_q;
    assign bus.clk_ir_en = clk_ir_en_q;
    assign bus.captureDR = capture_dr_q;
    assign bus.shiftDR   = shift_dr_q;
    assign bus.clk_dr_en = clk_dr_en_q;
    assign bus.tl_reset  = tl_reset_q;
    assign bus.updateIR  = update_ir_q;
    assign bus.updateDR  = update_dr_q;
    assign bus.tdo_en    = tdo_en_q;
    assign bus.ir_select = ir_select_q;

endmodule

// File: tb/tb_tap_controller.sv
// Self-checking bench for tap_controller: a table-driven TAP model pushes the
// expected state/controls for each tck cycle into a queue; they are popped and
// compared after the posedge and after the negedge of that cycle.
module tb_tap_controller;
    import jtag_pkg::*;

    logic tck;
    logic trst;

    tap_controller_if bus ();

    tap_controller dut (
        .tck  (tck),
        .trst (trst),
        .bus  (bus.slave)
    );

    typedef struct {
        logic [3:0] st;
        logic [5:0] pos;  // {captureIR, shiftIR, clk_ir_en, captureDR, shiftDR, clk_dr_en}
        logic [4:0] neg;  // {tl_reset, updateIR, updateDR, tdo_en, ir_select}
    } exp_t;

    exp_t exp_q[$];

    // Next-state tables indexed by the 4-bit state encoding
    logic [3:0] nxt0 [16] = '{4'h2, 4'h3, 4'h2, 4'h3, 4'hE, 4'hC, 4'h2, 4'h6,
                              4'hA, 4'hB, 4'hA, 4'hB, 4'hC, 4'hC, 4'hA, 4'hC};
    logic [3:0] nxt1 [16] = '{4'h5, 4'h5, 4'h1, 4'h0, 4'hF, 4'h7, 4'h1, 4'h4,
                              4'hD, 4'hD, 4'h9, 4'h8, 4'h7, 4'h7, 4'h9, 4'hF};

    localparam logic [15:0] IrSelMask = 16'hEF10;
    localparam logic [15:0] ShiftMask = 16'h0404;

    logic [3:0] m_state;
    int checks;
    int errors;
    int sh_ir_cnt, up_ir_cnt, up_dr_cnt, pause_cnt;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic exp_t model_out(input logic [3:0] s);
        exp_t e;
        e.st  = s;
        e.pos = {s == 4'hE, s == 4'hA, (s == 4'hE) || (s == 4'hA),
                 s == 4'h6, s == 4'h2, (s == 4'h6) || (s == 4'h2)};
        e.neg = {s != 4'hF, s == 4'hD, s == 4'h5, ShiftMask[s], IrSelMask[s]};
        return e;
    endfunction

    function automatic logic [5:0] pos_vec();
        return {bus.captureIR, bus.shiftIR, bus.clk_ir_en,
                bus.captureDR, bus.shiftDR, bus.clk_dr_en};
    endfunction

    function automatic logic [4:0] neg_vec();
        return {bus.tl_reset, bus.updateIR, bus.updateDR, bus.tdo_en, bus.ir_select};
    endfunction

    // One full tck cycle; tck is low on entry and on exit.
    task automatic tick(input logic t);
        exp_t e;
        bus.tms = t;
        m_state = t ? nxt1[m_state] : nxt0[m_state];
        exp_q.push_back(model_out(m_state));
        #4 tck = 1'b1;
        #1;
        e = exp_q.pop_front();
        check("state", 32'(bus.state), 32'(e.st));
        check("pos_ctl", 32'(pos_vec()), 32'(e.pos));
        sh_ir_cnt += int'(bus.shiftIR);
        pause_cnt += int'(bus.state == PAUSE_DR);
        #4 tck = 1'b0;
        #1;
        check("neg_ctl", 32'(neg_vec()), 32'(e.neg));
        check("onehot_ir", 32'($countones({bus.captureIR, bus.shiftIR, bus.updateIR}) <= 1), 1);
        check("onehot_dr", 32'($countones({bus.captureDR, bus.shiftDR, bus.updateDR}) <= 1), 1);
        up_ir_cnt += int'(bus.updateIR);
        up_dr_cnt += int'(bus.updateDR);
    endtask

    task automatic check_reset_vals(input string tag);
        check({tag, "_state"}, 32'(bus.state), 32'hF);
        check({tag, "_pos"}, 32'(pos_vec()), 32'h0);
        check({tag, "_neg"}, 32'(neg_vec()), 32'b00001);
    endtask

    // Asynchronous reset pulse with tck held low
    task automatic do_reset();
        trst = 1'b1;
        #2;
        check_reset_vals("rst");
        trst = 1'b0;
        #2;
        m_state = 4'hF;
        sh_ir_cnt = 0;
        up_ir_cnt = 0;
        up_dr_cnt = 0;
        pause_cnt = 0;
    endtask

    initial begin
        logic [3:0] seq;
        int n;
        checks  = 0;
        errors  = 0;
        tck     = 1'b0;
        trst    = 1'b0;
        bus.tms = 1'b1;
        m_state = 4'hF;
        #3;
        do_reset();

        // Reach every state, then five tms=1 edges must land in TLR.
        for (int tgt = 0; tgt < 16; tgt++) begin
            do_reset();
            n = 0;
            while ((m_state != 4'(tgt)) && (n < 300)) begin
                tick(1'($urandom_range(0, 1)));
                n++;
            end
            if (n >= 300) check("reach_bound", 32'(m_state), 32'(tgt));
            for (int i = 0; i < 5; i++) tick(1'b1);
            check("five_ones_tlr", 32'(bus.state), 32'hF);
            tick(1'b0);
            check("tlr_to_rti", 32'(bus.state), 32'hC);
            check("tl_reset_hi", 32'(bus.tl_reset), 1);
        end

        // IR scan: RTI -> SEL_DR -> SEL_IR -> CAP_IR -> SHIFT_IR x3 -> EXIT1 -> UPDATE -> RTI
        do_reset();
        tick(1'b0);
        seq = 4'b0011;  // applied LSB first: 1,1,0,0
        for (int i = 0; i < 4; i++) tick(seq[i]);
        tick(1'b0);
        tick(1'b0);
        tick(1'b1);
        tick(1'b1);
        check("ir_in_update", 32'(bus.updateIR), 1);
        tick(1'b0);
        check("ir_shift_cycles", 32'(sh_ir_cnt), 3);
        check("ir_update_width", 32'(up_ir_cnt), 1);

        // DR scan with a 3-cycle pause
        do_reset();
        tick(1'b0);
        tick(1'b1);
        tick(1'b0);
        tick(1'b0);
        tick(1'b0);
        tick(1'b0);
        tick(1'b1);
        tick(1'b0);
        tick(1'b0);
        tick(1'b0);
        tick(1'b1);
        tick(1'b0);
        tick(1'b1);
        tick(1'b1);
        tick(1'b0);
        check("dr_pause_cycles", 32'(pause_cnt), 3);
        check("dr_update_width", 32'(up_dr_cnt), 1);

        // Reset asserted while tck is high in SHIFT_IR
        do_reset();
        tick(1'b0);
        tick(1'b1);
        tick(1'b1);
        tick(1'b0);
        tick(1'b0);
        tick(1'b0);
        check("mid_shift_in", 32'({bus.shiftIR, bus.clk_ir_en, bus.tdo_en}), 32'b111);
        bus.tms = 1'b0;
        #4 tck = 1'b1;
        #1 trst = 1'b1;
        #1;
        check("mid_shift_drop", 32'({bus.shiftIR, bus.clk_ir_en, bus.tdo_en}), 32'b000);
        check_reset_vals("mid_shift");
        #3 tck = 1'b0;
        #1;
        check("mid_shift_no_upd", 32'(bus.updateIR), 0);
        trst = 1'b0;
        m_state = 4'hF;
        up_ir_cnt = 0;
        #4;
        for (int i = 0; i < 6; i++) tick(1'b1);
        check("mid_shift_no_upd_after", 32'(up_ir_cnt), 0);

        // Reset kills an update pulse already in flight
        do_reset();
        tick(1'b0);
        tick(1'b1);
        tick(1'b1);
        tick(1'b0);
        tick(1'b1);
        tick(1'b1);
        check("upd_in_flight", 32'(bus.updateIR), 1);
        trst = 1'b1;
        #1;
        check("upd_cleared", 32'(bus.updateIR), 0);
        check_reset_vals("upd_rst");
        trst = 1'b0;
        m_state = 4'hF;
        #3;

        // Random tms stream
        do_reset();
        for (int i = 0; i < 10000; i++) tick(1'($urandom_range(0, 1)));
        check("queue_drained", 32'(exp_q.size()), 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
